// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS core front end.
//   - Primary opcode values seen in IR[31:26]
//   - Fetch FSM state encoding (plain localparams so older tools that
//     mishandle enums can still read this package)
//   - NOP word used as the IR reset value
//   - Helpers for the sign-extended branch offset and the J-type target
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Fetch FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // All-zero word decodes as sll $0,$0,0, i.e. a harmless NOP
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Branch immediate as a byte offset: sign-extend and scale by 4
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // J-type target keeps the 256 MB region of the delay-slot address
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen
//   Combinational next-PC selection for the fetch stage. Kept free of any
//   state so a later pipelined fetch can reuse it unchanged.
// Ports
//   pc_plus4     in   32  address of the instruction after the one in IR
//   instr_index  in   26  IR[25:0]; J-type index, low 16 bits are the
//                         branch immediate
//   branch       in   1   beq or bne in IR
//   branch_ne    in   1   bne in IR (selects the inverted zero test)
//   jump         in   1   j or jal in IR
//   zero         in   1   ALU zero flag for the instruction in IR
//   next_pc      out  32  jump target > taken branch target > pc_plus4
module next_pc_gen
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic        taken;
  logic [31:0] branch_dest;
  logic [31:0] jump_dest;

  // bne takes the branch when the operands differ, beq when they match
  assign taken       = branch & (branch_ne ? ~zero : zero);
  // 32-bit add, carry dropped: branches wrap around the address space
  assign branch_dest = pc_plus4 + branch_offset(instr_index[15:0]);
  assign jump_dest   = jump_target(pc_plus4[31:28], instr_index);

  // Jump outranks a branch so a confused decoder asserting both still
  // behaves like the jump it most likely decoded.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_dest;
    end else if (taken) begin
      next_pc = branch_dest;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage for the MIPS core. Owns the PC, fetches one
//   word at a time over a req/ack handshake, holds it in IR until the
//   downstream stage consumes it, then steps the PC using the control
//   decoder's branch/jump outputs and the ALU zero flag.
// Parameters
//   RESET_PC     PC loaded on reset; must be word aligned
// Ports
//   clk          in   1   single clock, rising edge
//   rst          in   1   synchronous active-high reset
//   imem_req     out  1   fetch request; imem_addr stable while high
//   imem_addr    out  32  word-aligned fetch address (= pc)
//   imem_ack     in   1   imem_rdata valid; ignored unless imem_req
//   imem_rdata   in   32  fetched instruction word
//   instr        out  32  IR contents
//   op           out  6   IR[31:26] for the main control decoder
//   pc_plus4     out  32  pc + 4, for jal link / branch base
//   instr_valid  out  1   IR holds an instruction not yet consumed
//   instr_ready  in   1   downstream consumes IR this cycle
//   branch       in   1   beq or bne decoded
//   branch_ne    in   1   bne decoded
//   jump         in   1   j or jal decoded
//   zero         in   1   ALU zero flag for the instruction in IR
//   fetch_count  out  32  consumed instructions, wraps mod 2^32
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] fetch_count
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        valid_q;
  logic [31:0] count_q;
  logic [31:0] next_pc;
  logic        load_ir;
  logic        consume;

  // A word is captured only while we are actually requesting; an ack in
  // S_IDLE or S_HOLD is a stray from memory and must not disturb IR.
  assign load_ir = (state == S_FETCH) && imem_ack;

  // The branch/jump inputs only mean something in this cycle; elsewhere
  // the decoder may be looking at garbage and we ignore it.
  assign consume = (state == S_HOLD) && valid_q && instr_ready;

  next_pc_gen u_next_pc_gen (
    .pc_plus4    (pc_plus4),
    .instr_index (ir[25:0]),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .zero        (zero),
    .next_pc     (next_pc)
  );

  // Fetch FSM. S_IDLE is a single dead cycle after reset so memory sees
  // req low and drops any request that was in flight when rst hit.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (load_ir) state_next = S_HOLD;
      S_HOLD:  if (consume) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC only moves when IR is handed downstream, so imem_addr cannot
  // change while a request is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (consume) begin
      pc <= next_pc;
    end
  end

  // IR resets to a NOP so op is a defined R-type code straight out of
  // reset rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= NOP_WORD;
    end else if (load_ir) begin
      ir <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (load_ir) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // Counts retired fetches; plain binary wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else if (consume) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign instr       = ir;
  // Decoder sees the registered IR only, never imem_rdata directly.
  assign op          = ir[31:26];
  assign instr_valid = valid_q;
  assign fetch_count = count_q;

endmodule
